mtm_alu_tx: RTL and testbench
=============================

MTM_ALU_TX -- requirements
Module: mtm_alu_tx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports below in order.
REQ-002 clk  input  1  rising-edge clock, one line bit per cycle.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 valid  input  1  result/error word present on the inputs.
REQ-005 ready  output  1  block idle and able to accept a word.
REQ-006 err  input  1  1 = send error frame; 0 = send result frame.
REQ-007 C  input  32  ALU result.
REQ-008 flags  input  4  ALU status flags.
REQ-009 err_flags  input  6  error flags.
REQ-010 sout  output  1  serial output, idle high.

Function
REQ-011 Each line byte SHALL be 11 bits, one per clk: start 0, type bit (0 = DATA, 1 = CTL), 8 payload bits MSB first, stop 1.
REQ-012 A word SHALL be accepted on the rising edge where valid && ready; all inputs are sampled only at that edge.
REQ-013 ready SHALL be 1 only in IDLE; valid while ready = 0 SHALL be ignored.
REQ-014 Result frame (err = 0) SHALL be DATA C[31:24], C[23:16], C[15:8], C[7:0], then CTL {1'b0, flags, crc3}: 55 cycles.
REQ-015 Error frame (err = 1) SHALL be one CTL byte {1'b1, err_flags, parity}, where parity = XOR of payload bits 7:1: 11 cycles. C and flags are ignored.
REQ-016 crc3 SHALL use polynomial x^3+x+1 with initial value 0. The message is the 40-bit vector {C, 1'b0, flags, 3'b000}, shifted MSB first.
REQ-017 sout SHALL be registered; the start bit of the first byte appears on sout in the cycle after the accept edge.
REQ-018 Bytes within a frame SHALL be back to back, with no idle bits between them.
REQ-019 FSM states SHALL be IDLE, START, TYPE, PAYLOAD (3-bit bit counter, 7 down to 0), STOP. A byte counter (0..4) selects the payload byte.
REQ-020 After the last STOP cycle the FSM SHALL enter IDLE, and ready SHALL be 1 in the following cycle; the earliest next start bit is 2 cycles after the last stop bit.
REQ-021 sout SHALL be 1 in IDLE.

Reset
REQ-022 While rst = 1: sout = 1, ready = 0, state = IDLE, and all counters and holding registers are cleared.
REQ-023 Reset mid-frame SHALL abandon the frame immediately (asynchronously), with no partial byte completion.
REQ-024 ready SHALL go to 1 on the first clk edge after rst deasserts.

Configuration
REQ-025 Macro MTM_ALU_TX_CRC_EN defined: crc3 is computed per REQ-016 and the CRC sub-module is instantiated.
REQ-026 Macro MTM_ALU_TX_CRC_EN undefined: the crc3 field is transmitted as 3'b000, the CRC sub-module is not instantiated, and timing is unchanged.

Structure
REQ-027 Package mtm_alu_pkg SHALL hold:
- byte type enum {DATA, CTL}
- FSM state enum
- constant BYTE_BITS = 11
- constant RESULT_BYTES = 5
- CTL marker bit values (0 = result, 1 = error)
REQ-028 Combinational sub-module mtm_alu_crc3 (inputs C, flags; output crc[2:0]) SHALL compute the CRC; it is shared with future checkers.

Verification
REQ-029 C = 32'h0000_0000, flags = 4'h0, CRC enabled -> bytes DATA 00 x4, CTL 00; sout bit stream 00_00000000_1 x4 then 01_00000000_1; 55 cycles.
REQ-030 C = 32'h0000_0000, flags = 4'b0001, CRC enabled -> CTL byte 8'h0B (crc3 = 3'b011); with MTM_ALU_TX_CRC_EN undefined -> CTL byte 8'h08.
REQ-031 C = 32'h0102_0304, flags = 4'h0 -> DATA bytes 01, 02, 03, 04 in that order; ready low for all 55 cycles, then high one cycle after the final stop.
REQ-032 err = 1, err_flags = 6'b100000 -> single CTL byte 8'hC0 (parity 0), stream 0_1_11000000_1; err_flags = 6'b100001 -> CTL byte 8'hC3 (parity 1).
REQ-033 Second valid held continuously during a frame -> ignored until ready = 1, then accepted; the next start bit follows 2 cycles after the previous stop bit.
REQ-034 rst asserted during the PAYLOAD of byte 2 -> sout = 1 immediately, ready = 0 while rst = 1, ready = 1 one edge after release; a new frame then transmits correctly.

Source files
------------

// File: rtl/mtm_alu_pkg.sv
// mtm_alu_pkg: shared types and constants for the MTM ALU serial transmitter.
package mtm_alu_pkg;

    typedef enum logic {DATA = 1'b0, CTL = 1'b1} byte_type_e;

    typedef enum logic [2:0] {IDLE, START, TYPE, PAYLOAD, STOP} state_e;

    localparam int BYTE_BITS    = 11;
    localparam int RESULT_BYTES = 5;

    localparam logic CTL_RESULT = 1'b0;
    localparam logic CTL_ERROR  = 1'b1;

endpackage

// File: rtl/mtm_alu_crc3.sv
// mtm_alu_crc3: remainder of {C, 0, flags, 000} modulo x^3+x+1, MSB first, init 0.
module mtm_alu_crc3 (
    input  logic [31:0] C,
    input  logic [3:0]  flags,
    output logic [2:0]  crc
);

    logic [39:0] msg;

    assign msg = {C, 1'b0, flags, 3'b000};

    // Long-division form: shift in a bit, fold back x^3 = x + 1 on overflow.
    always_comb begin
        crc = 3'b000;
        for (int i = 39; i >= 0; i--)
            crc = {crc[1:0], msg[i]} ^ (crc[2] ? 3'b011 : 3'b000);
    end

endmodule

// File: rtl/mtm_alu_tx.sv
// mtm_alu_tx: serialises ALU result/error words into 11-bit line bytes on sout.
// Define MTM_ALU_TX_CRC_EN to compute crc3; otherwise the field is sent as zero.
module mtm_alu_tx
    import mtm_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    output logic        ready,
    input  logic        err,
    input  logic [31:0] C,
    input  logic [3:0]  flags,
    input  logic [5:0]  err_flags,
    output logic        sout
);

    state_e      state;
    logic [2:0]  bit_cnt;
    logic [2:0]  byte_cnt;
    logic [31:0] c_q;
    logic [3:0]  flags_q;
    logic [5:0]  ef_q;
    logic        err_q;
    logic [2:0]  crc;
    logic [7:0]  data_byte;
    logic [7:0]  payload;
    logic        last_byte;
    byte_type_e  btype;

`ifdef MTM_ALU_TX_CRC_EN
    mtm_alu_crc3 u_crc (
        .C     (c_q),
        .flags (flags_q),
        .crc   (crc)
    );
`else
    assign crc = 3'b000;
`endif

    always_comb begin
        data_byte = byte_cnt == 3'd0 ? c_q[31:24] :
                    byte_cnt == 3'd1 ? c_q[23:16] :
                    byte_cnt == 3'd2 ? c_q[15:8]  : c_q[7:0];
        payload   = err_q ? {CTL_ERROR, ef_q, ^{CTL_ERROR, ef_q}} :
                    byte_cnt == 3'(RESULT_BYTES - 1) ? {CTL_RESULT, flags_q, crc} : data_byte;
        btype     = (err_q || byte_cnt == 3'(RESULT_BYTES - 1)) ? CTL : DATA;
        last_byte = err_q || byte_cnt == 3'(RESULT_BYTES - 1);
    end

    // State names the bit currently on sout; sout is loaded with the next state's bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sout     <= 1'b1;
            ready    <= 1'b0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            c_q      <= '0;
            flags_q  <= '0;
            ef_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sout <= 1'b1;
                    if (valid && ready) begin
                        c_q      <= C;
                        flags_q  <= flags;
                        ef_q     <= err_flags;
                        err_q    <= err;
                        byte_cnt <= '0;
                        ready    <= 1'b0;
                        sout     <= 1'b0;
                        state    <= START;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                START: begin
                    sout  <= btype;
                    state <= TYPE;
                end
                TYPE: begin
                    sout    <= payload[7];
                    bit_cnt <= 3'd7;
                    state   <= PAYLOAD;
                end
                PAYLOAD: begin
                    if (bit_cnt == 3'd0) begin
                        sout  <= 1'b1;
                        state <= STOP;
                    end else begin
                        sout    <= payload[bit_cnt - 3'd1];
                        bit_cnt <= bit_cnt - 3'd1;
                    end
                end
                STOP: begin
                    if (last_byte) begin
                        sout  <= 1'b1;
                        ready <= 1'b1;
                        state <= IDLE;
                    end else begin
                        sout     <= 1'b0;
                        byte_cnt <= byte_cnt + 3'd1;
                        state    <= START;
                    end
                end
                default: begin
                    sout  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mtm_alu_tx.sv
// tb_mtm_alu_tx: random and directed frames checked bit by bit against a frame model.
module tb_mtm_alu_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        ready;
    logic        err = 1'b0;
    logic [31:0] c_in = '0;
    logic [3:0]  flags = '0;
    logic [5:0]  err_flags = '0;
    logic        sout;

    int errors = 0;
    int checks = 0;
    bit exp_bits[$];

    mtm_alu_tx dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .ready     (ready),
        .err       (err),
        .C         (c_in),
        .flags     (flags),
        .err_flags (err_flags),
        .sout      (sout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] model_crc(input logic [31:0] c, input logic [3:0] f);
        logic [39:0] m;
        m = {c, 1'b0, f, 3'b000};
        for (int i = 39; i >= 3; i--)
            if (m[i]) m[i -: 4] = m[i -: 4] ^ 4'b1011;
        return m[2:0];
    endfunction

    function automatic void build(input logic e, input logic [31:0] c, input logic [3:0] f,
                                  input logic [5:0] ef);
        logic [8:0] bytes[$];
        logic [2:0] crc;
        exp_bits.delete();
`ifdef MTM_ALU_TX_CRC_EN
        crc = model_crc(c, f);
`else
        crc = 3'b000;
`endif
        if (e) begin
            bytes.push_back({1'b1, 1'b1, ef, 1'(($countones(ef) + 1) % 2)});
        end else begin
            for (int k = 3; k >= 0; k--) bytes.push_back({1'b0, c[8*k +: 8]});
            bytes.push_back({1'b1, 1'b0, f, crc});
        end
        foreach (bytes[i]) begin
            exp_bits.push_back(1'b0);
            exp_bits.push_back(bytes[i][8]);
            for (int b = 7; b >= 0; b--) exp_bits.push_back(bytes[i][b]);
            exp_bits.push_back(1'b1);
        end
    endfunction

    task automatic start_word(input logic e, input logic [31:0] c, input logic [3:0] f,
                              input logic [5:0] ef, input bit hold);
        int n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", ready, 1);
        valid = 1'b1; err = e; c_in = c; flags = f; err_flags = ef;
        @(posedge clk);
        #1;
        if (!hold) begin
            valid = 1'b0;
            err = 1'($urandom); c_in = $urandom; flags = 4'($urandom); err_flags = 6'($urandom);
        end
    endtask

    task automatic expect_frame(input logic e, input logic [31:0] c, input logic [3:0] f,
                                input logic [5:0] ef);
        build(e, c, f, ef);
        foreach (exp_bits[i]) begin
            @(negedge clk);
            chk($sformatf("sout[%0d]", i), sout, exp_bits[i]);
            chk("busy_ready", ready, 0);
        end
        @(negedge clk);
        chk("idle_ready", ready, 1);
        chk("idle_sout", sout, 1);
    endtask

    task automatic frame(input logic e, input logic [31:0] c, input logic [3:0] f,
                         input logic [5:0] ef);
        start_word(e, c, f, ef, 1'b0);
        expect_frame(e, c, f, ef);
    endtask

    initial begin
        logic        re;
        logic [31:0] rc;
        logic [3:0]  rf;
        logic [5:0]  ref_ef;

        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_sout", sout, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", ready, 1);

        frame(1'b0, 32'h0000_0000, 4'h0, 6'h00);
        frame(1'b0, 32'h0000_0000, 4'b0001, 6'h00);
        frame(1'b0, 32'h0102_0304, 4'h0, 6'h00);
        frame(1'b1, 32'hDEAD_BEEF, 4'hF, 6'b100000);
        frame(1'b1, 32'h1234_5678, 4'h5, 6'b100001);

        // Held valid: second word waits for ready, start bit two cycles after last stop.
        start_word(1'b0, 32'hA5A5_0F0F, 4'h9, 6'h00, 1'b1);
        c_in = 32'h8001_7FFE; flags = 4'h6; err = 1'b0;
        expect_frame(1'b0, 32'hA5A5_0F0F, 4'h9, 6'h00);
        @(posedge clk);
        #1 valid = 1'b0;
        expect_frame(1'b0, 32'h8001_7FFE, 4'h6, 6'h00);

        // Reset in the payload of the third byte (all zero there).
        start_word(1'b0, 32'hFFFF_00FF, 4'h3, 6'h00, 1'b0);
        repeat (26) @(negedge clk);
        chk("pre_rst_sout", sout, 0);
        rst = 1'b1;
        #1;
        chk("async_rst_sout", sout, 1);
        chk("async_rst_ready", ready, 0);
        repeat (2) begin
            @(negedge clk);
            chk("held_rst_sout", sout, 1);
            chk("held_rst_ready", ready, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("release_ready", ready, 1);
        frame(1'b0, 32'hCAFE_F00D, 4'hA, 6'h00);

        for (int t = 0; t < 25; t++) begin
            re = 1'($urandom_range(0, 3) == 0);
            rc = $urandom;
            rf = 4'($urandom);
            ref_ef = 6'($urandom);
            frame(re, rc, rf, ref_ef);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
